insn_fetch_unit: RTL and testbench



---
 rtl/insn_fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_insn_fetch_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : insn_fetch_unit
// Purpose  : PC generator and fetch buffer sitting directly in front of the
//            instruction memory. Issues one word address per cycle while
//            queue credit is available. Captures the word the memory returns
//            one cycle later and queues it with its PC. Hands words to decode
//            through a valid/ready handshake. A redirect flushes everything
//            fetched but not yet delivered and restarts fetch at the target.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               in   1           clock
//   rst               in   1           synchronous active-high reset
//   imem_addr_o       out  ADDR_WIDTH  byte address to instruction memory
//   imem_insn_i       in   INSN_WIDTH  word for the address latched last edge
//   redirect_valid_i  in   1           redirect fetch this cycle
//   redirect_pc_i     in   ADDR_WIDTH  redirect target (bits [1:0] ignored)
//   out_valid_o       out  1           queue head valid
//   out_insn_o        out  INSN_WIDTH  queue head instruction
//   out_pc_o          out  ADDR_WIDTH  queue head PC
//   out_ready_i       in   1           decode accepts head
// ============================================================================
module insn_fetch_unit #(
    parameter int                    INSN_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [INSN_WIDTH-1:0] imem_insn_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  out_valid_o,
    output logic [INSN_WIDTH-1:0] out_insn_o,
    output logic [ADDR_WIDTH-1:0] out_pc_o,
    input  logic                  out_ready_i
);

    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0]  c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W:0]    c_DEPTH_EXT  = (c_CNT_W + 1)'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP  = ADDR_WIDTH'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] fetch_pc_q,    fetch_pc_d;
    logic                  inflight_q,    inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [c_PTR_W-1:0]    head_q,        head_d;
    logic [c_PTR_W-1:0]    tail_q,        tail_d;
    logic [c_CNT_W-1:0]    count_q,       count_d;

    // Queue storage; not reset because out_valid_o gates what is visible.
    logic [INSN_WIDTH-1:0] insn_mem_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_q   [QUEUE_DEPTH];

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_redirect_aligned;
    logic                  w_unused_ok;

    // Credit counts the word already in flight, so a push can never find
    // the queue full: the memory has no back-pressure, and a returned word
    // must always have a slot waiting for it.
    assign w_credit_ok = ({1'b0, count_q} + {{c_CNT_W{1'b0}}, inflight_q})
                         < c_DEPTH_EXT;

    assign w_issue = !rst && !redirect_valid_i && w_credit_ok;

    // A word returning in a redirect cycle belongs to the old path.
    assign w_push  = inflight_q && !redirect_valid_i && !rst;

    assign w_pop   = out_valid_o && out_ready_i;

    assign w_redirect_aligned = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

    // Low address bits of the redirect target are deliberately dropped.
    assign w_unused_ok = &{1'b0, redirect_pc_i[1:0]};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr_o = fetch_pc_q;
    assign out_valid_o = (count_q != '0);

    // Head is read straight out of queue registers, never from imem_insn_i,
    // so decode sees no combinational path from the memory.
    assign out_insn_o  = out_valid_o ? insn_mem_q[head_q] : '0;
    assign out_pc_o    = out_valid_o ? pc_mem_q[head_q]   : '0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        if (redirect_valid_i) begin
            // Flush: anything queued or in flight is on the wrong path. A
            // handshake in this cycle has already delivered its word, so
            // dropping the head here loses nothing.
            fetch_pc_d = w_redirect_aligned;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (w_issue) begin
                // Wraps modulo 2^ADDR_WIDTH with no special case.
                fetch_pc_d    = fetch_pc_q + c_PC_STEP;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end

            if (w_push) begin
                tail_d = tail_q + c_PTR_ONE;
            end

            if (w_pop) begin
                head_d = head_q + c_PTR_ONE;
            end

            unique case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_ONE;
                2'b01:   count_d = count_q - c_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Queue storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            insn_mem_q[tail_q] <= imem_insn_i;
            pc_mem_q[tail_q]   <= inflight_pc_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_insn_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_insn_fetch_unit
// Purpose  : Self-checking bench for insn_fetch_unit. A registered memory
//            model returns A000_0000 + word index. A 32-bit instance covers
//            streaming, back-pressure, redirects and reset. An 8-bit-address
//            instance covers PC wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_insn_fetch_unit;

    localparam int c_DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_insn;
    logic        out_valid;
    logic [31:0] out_insn;
    logic [31:0] out_pc;

    // 8-bit address instance
    logic        rst8 = 1'b1;
    logic        redirect_valid8 = 1'b0;
    logic [7:0]  redirect_pc8 = '0;
    logic        out_ready8 = 1'b0;
    logic [7:0]  imem_addr8;
    logic [31:0] imem_insn8;
    logic        out_valid8;
    logic [31:0] out_insn8;
    logic [7:0]  out_pc8;

    insn_fetch_unit #(
        .INSN_WIDTH (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0),
        .QUEUE_DEPTH(c_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr_o     (imem_addr),
        .imem_insn_i     (imem_insn),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .out_valid_o     (out_valid),
        .out_insn_o      (out_insn),
        .out_pc_o        (out_pc),
        .out_ready_i     (out_ready)
    );

    insn_fetch_unit #(
        .INSN_WIDTH (32),
        .ADDR_WIDTH (8),
        .RESET_PC   (8'h0),
        .QUEUE_DEPTH(c_DEPTH)
    ) dut8 (
        .clk             (clk),
        .rst             (rst8),
        .imem_addr_o     (imem_addr8),
        .imem_insn_i     (imem_insn8),
        .redirect_valid_i(redirect_valid8),
        .redirect_pc_i   (redirect_pc8),
        .out_valid_o     (out_valid8),
        .out_insn_o      (out_insn8),
        .out_pc_o        (out_pc8),
        .out_ready_i     (out_ready8)
    );

    // Memory: address latched at the edge, word visible the following cycle.
    always @(posedge clk) imem_insn  <= 32'hA000_0000 + (imem_addr >> 2);
    always @(posedge clk) imem_insn8 <= 32'hA000_0000 + {26'd0, imem_addr8[7:2]};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'hA000_0000 + (pc >> 2);
    endfunction

    // Scoreboard of expected deliveries on the 32-bit instance.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t sb[$];
    logic sb_en = 1'b0;

    task automatic sb_push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.insn = word_of(pc);
        sb.push_back(e);
    endtask

    // Sample mid-cycle; a handshake seen here completes at the next edge.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (sb_en && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got pc %h, expected no delivery", out_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", out_pc, e.pc);
                check("sb_insn", out_insn, e.insn);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sb_en          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        rst            = 1'b1;
        adv();
        adv();
        sb.delete();
    endtask

    // Overflow guard: credit accounting must keep the queue within depth.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (dut.count_q > 3'(c_DEPTH)) begin
                errors++;
                $display("FAIL overflow: got count %0d, expected <= %0d", dut.count_q, c_DEPTH);
            end
        end
    end

    // Table of per-cycle vectors for the back-pressure scenario.
    typedef struct {
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[16];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        // Back-pressure vectors from reset release (cycle 0 onward).
        tbl[0]  = '{1'b0, 1'b0, 32'h00, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 32'h00, 32'h04};
        tbl[2]  = '{1'b0, 1'b1, 32'h00, 32'h08};
        tbl[3]  = '{1'b0, 1'b1, 32'h00, 32'h0C};
        for (int i = 4; i < 10; i++) tbl[i] = '{1'b0, 1'b1, 32'h00, 32'h10};
        tbl[10] = '{1'b1, 1'b1, 32'h00, 32'h10};
        tbl[11] = '{1'b1, 1'b1, 32'h04, 32'h10};
        tbl[12] = '{1'b1, 1'b1, 32'h08, 32'h14};
        tbl[13] = '{1'b1, 1'b1, 32'h0C, 32'h18};
        tbl[14] = '{1'b1, 1'b1, 32'h10, 32'h1C};
        tbl[15] = '{1'b1, 1'b1, 32'h14, 32'h20};

        // ---------------- Reset state ----------------
        adv();
        adv();
        sample();
        check("rst_valid", out_valid, 1'b0);
        check("rst_insn",  out_insn,  32'h0);
        check("rst_pc",    out_pc,    32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst8_valid", out_valid8, 1'b0);
        check("rst8_addr",  imem_addr8, 8'h00);
        adv();

        // ---------------- 1: streaming from reset ----------------
        rst = 1'b0; out_ready = 1'b1; sb_en = 1'b1;
        for (int i = 0; i < 10; i++) sb_push(32'(i * 4));
        for (int c = 0; c < 12; c++) begin
            sample();
            check("t1_valid", out_valid, (c >= 2));
            check("t1_addr",  imem_addr, 32'(c * 4));
            adv();
        end
        check("t1_sb_left", sb.size(), 0);

        // ---------------- 2: back-pressure table ----------------
        do_reset();
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            out_ready = tbl[c].rdy;
            sample();
            check("t2_valid", out_valid, tbl[c].exp_valid);
            check("t2_pc",    out_pc,    tbl[c].exp_pc);
            check("t2_insn",  out_insn,
                  tbl[c].exp_valid ? word_of(tbl[c].exp_pc) : 32'h0);
            check("t2_addr",  imem_addr, tbl[c].exp_addr);
            adv();
        end

        // ---------------- 3: redirect with pc 8 at head ----------------
        do_reset();
        rst = 1'b0; out_ready = 1'b1; sb_en = 1'b1;
        sb_push(32'h0); sb_push(32'h4); sb_push(32'h8);
        for (int c = 0; c < 4; c++) begin
            sample();
            adv();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        sb_push(32'h40); sb_push(32'h44); sb_push(32'h48);
        sample();
        check("t3_head_r", out_pc, 32'h8);
        adv();
        redirect_valid = 1'b0;
        sample();
        check("t3_valid_r1", out_valid, 1'b0);
        check("t3_addr_r1",  imem_addr, 32'h40);
        adv();
        sample();
        check("t3_valid_r2", out_valid, 1'b0);
        adv();
        for (int c = 0; c < 3; c++) begin
            sample();
            check("t3_valid_after", out_valid, 1'b1);
            adv();
        end
        check("t3_sb_left", sb.size(), 0);

        // ---------------- 4: unaligned redirect target ----------------
        do_reset();
        rst = 1'b0; out_ready = 1'b1; sb_en = 1'b1;
        sb_push(32'h0); sb_push(32'h4);
        for (int c = 0; c < 3; c++) begin
            sample();
            adv();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h43;
        sb_push(32'h40); sb_push(32'h44);
        sample();
        adv();
        redirect_valid = 1'b0;
        sample();
        check("t4_addr_r1", imem_addr, 32'h40);
        adv();
        sample();
        adv();
        sample();
        check("t4_pc", out_pc, 32'h40);
        adv();
        sample();
        adv();
        check("t4_sb_left", sb.size(), 0);

        // ---------------- 5: reset pulse with 3 queued ----------------
        do_reset();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample();
            adv();
        end
        sample();
        check("t5_valid_pre", out_valid, 1'b1);
        rst = 1'b1;
        adv();
        rst = 1'b0; out_ready = 1'b1; sb_en = 1'b1;
        sb_push(32'h0); sb_push(32'h4); sb_push(32'h8); sb_push(32'hC);
        for (int c = 0; c < 6; c++) begin
            sample();
            check("t5_valid", out_valid, (c >= 2));
            if (c == 0) check("t5_addr", imem_addr, 32'h0);
            adv();
        end
        check("t5_sb_left", sb.size(), 0);

        // ---------------- 7: back-to-back redirects ----------------
        do_reset();
        rst = 1'b0; out_ready = 1'b1; sb_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        sample();
        adv();
        redirect_pc = 32'h100;
        sb_push(32'h100); sb_push(32'h104);
        sample();
        adv();
        redirect_valid = 1'b0;
        sample();
        check("t7_addr", imem_addr, 32'h100);
        check("t7_valid_r1", out_valid, 1'b0);
        adv();
        sample();
        check("t7_valid_r2", out_valid, 1'b0);
        adv();
        for (int c = 0; c < 2; c++) begin
            sample();
            check("t7_valid", out_valid, 1'b1);
            adv();
        end
        check("t7_sb_left", sb.size(), 0);

        // Redirect together with reset: reset wins.
        sb_en = 1'b0; out_ready = 1'b0;
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        adv();
        rst = 1'b0; redirect_valid = 1'b0;
        sample();
        check("t8_addr", imem_addr, 32'h0);
        check("t8_valid", out_valid, 1'b0);
        adv();

        // ---------------- 6: 8-bit PC wrap ----------------
        rst8 = 1'b0; out_ready8 = 1'b1;
        redirect_valid8 = 1'b1; redirect_pc8 = 8'hFC;
        sample();
        check("t6_addr_r", imem_addr8, 8'h00);
        adv();
        redirect_valid8 = 1'b0;
        sample();
        check("t6_addr_r1", imem_addr8, 8'hFC);
        check("t6_valid_r1", out_valid8, 1'b0);
        adv();
        sample();
        check("t6_addr_r2", imem_addr8, 8'h00);
        check("t6_valid_r2", out_valid8, 1'b0);
        adv();
        sample();
        check("t6_valid_a", out_valid8, 1'b1);
        check("t6_pc_a",    out_pc8,    8'hFC);
        check("t6_insn_a",  out_insn8,  32'hA000_003F);
        adv();
        sample();
        check("t6_valid_b", out_valid8, 1'b1);
        check("t6_pc_b",    out_pc8,    8'h00);
        check("t6_insn_b",  out_insn8,  32'hA000_0000);
        adv();
        sample();
        check("t6_pc_c",    out_pc8,    8'h04);
        adv();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
